// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared constants for the SR register bank.
//   SR_MODE_*        S=R=1 resolution modes (reset-dominant, set-dominant, toggle, hold-and-flag)
//   SR_CNT_W_DEFAULT default width of the illegal-event counter
//   sr_mode_legal()  true when a MODE value is one of the supported modes
package sr_bank_pkg;

   localparam int unsigned SR_MODE_RDOM   = 0;
   localparam int unsigned SR_MODE_SDOM   = 1;
   localparam int unsigned SR_MODE_TOGGLE = 2;
   localparam int unsigned SR_MODE_HOLD   = 3;

   localparam int unsigned SR_CNT_W_DEFAULT = 8;

   function automatic bit sr_mode_legal(input int unsigned mode);
      return mode <= SR_MODE_HOLD;
   endfunction

endpackage

// File: rtl/sr_register_bank_if.sv
// sr_register_bank_if: control/status bundle of the SR register bank.
//   en        update enable
//   S, R      per-channel set / reset requests
//   clr_err   clear of err_flag and err_cnt
//   Q, nQ     stored state and its complement
//   err_flag  sticky per-channel illegal-input flags
//   err_cnt   saturating count of cycles with any illegal channel
// Modports: master drives requests and observes state; slave is the register bank.
interface sr_register_bank_if
   import sr_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = SR_CNT_W_DEFAULT
);

   logic             en;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic             clr_err;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] nQ;
   logic [WIDTH-1:0] err_flag;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output en, S, R, clr_err,
      input  Q, nQ, err_flag, err_cnt
   );

   modport slave (
      input  en, S, R, clr_err,
      output Q, nQ, err_flag, err_cnt
   );

endinterface

// File: rtl/sr_cell.sv
// sr_cell: one edge-triggered SR storage channel.
//   clk, nRst  rising-edge clock, asynchronous active-low reset
//   en         update enable (holds state when low)
//   s, r       set / reset requests
//   init_val   value loaded into q on reset
//   q, nq      stored state and its registered complement
//   illegal    combinational pulse: enabled S=R=1 in a mode where that is illegal
// Parameter MODE selects S=R=1 resolution (see sr_bank_pkg).
// Build option SR_BANK_SYNC_EN: s and r pass through a 2-flop synchroniser first.
module sr_cell
   import sr_bank_pkg::*;
#(
   parameter int unsigned MODE = SR_MODE_RDOM
) (
   input  logic clk,
   input  logic nRst,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic init_val,
   output logic q,
   output logic nq,
   output logic illegal
);

   if (!sr_mode_legal(MODE)) begin : g_mode_check
      $error("sr_cell: unsupported MODE %0d", MODE);
   end

   logic s_eff;
   logic r_eff;

`ifdef SR_BANK_SYNC_EN
   logic s_meta_q, s_sync_q;
   logic r_meta_q, r_sync_q;

   // Free-running synchroniser: en only gates the storage flop.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         s_meta_q <= 1'b0;
         s_sync_q <= 1'b0;
         r_meta_q <= 1'b0;
         r_sync_q <= 1'b0;
      end else begin
         s_meta_q <= s;
         s_sync_q <= s_meta_q;
         r_meta_q <= r;
         r_sync_q <= r_meta_q;
      end
   end

   assign s_eff = s_sync_q;
   assign r_eff = r_sync_q;
`else
   assign s_eff = s;
   assign r_eff = r;
`endif

   logic q_q;
   logic nq_q;
   logic q_d;
   logic both_q;

   always_comb begin
      if (MODE == SR_MODE_RDOM) begin
         both_q = 1'b0;
      end else if (MODE == SR_MODE_SDOM) begin
         both_q = 1'b1;
      end else if (MODE == SR_MODE_TOGGLE) begin
         both_q = ~q_q;
      end else begin
         both_q = q_q;
      end
   end

   always_comb begin
      q_d = q_q;
      case ({s_eff, r_eff})
         2'b10:   q_d = 1'b1;
         2'b01:   q_d = 1'b0;
         2'b11:   q_d = both_q;
         default: q_d = q_q;
      endcase
   end

   // nq has its own flop so it is a registered complement, never a decoded glitch.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         q_q  <= init_val;
         nq_q <= ~init_val;
      end else if (en) begin
         q_q  <= q_d;
         nq_q <= ~q_d;
      end
   end

   assign q       = q_q;
   assign nq      = nq_q;
   assign illegal = en & s_eff & r_eff & (MODE != SR_MODE_TOGGLE);

endmodule

// File: rtl/sr_register_bank.sv
// sr_register_bank: WIDTH independent SR channels with illegal-input monitoring.
//   clk, nRst  rising-edge clock, asynchronous active-low reset
//   bus        sr_register_bank_if slave: en, S, R, clr_err in; Q, nQ, err_flag, err_cnt out
// Parameters: WIDTH channels, MODE S=R=1 resolution, INIT_VAL reset value of Q,
//             CNT_W illegal-event counter width (saturating).
// Build option SR_BANK_SYNC_EN: S/R synchronised inside each cell (latency 3 edges).
module sr_register_bank
   import sr_bank_pkg::*;
#(
   parameter int unsigned      WIDTH    = 4,
   parameter int unsigned      MODE     = SR_MODE_RDOM,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   parameter int unsigned      CNT_W    = SR_CNT_W_DEFAULT
) (
   input logic               clk,
   input logic               nRst,
   sr_register_bank_if.slave bus
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] illegal;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(
         .MODE (MODE)
      ) u_cell (
         .clk      (clk),
         .nRst     (nRst),
         .en       (bus.en),
         .s        (bus.S[i]),
         .r        (bus.R[i]),
         .init_val (INIT_VAL[i]),
         .q        (q[i]),
         .nq       (nq[i]),
         .illegal  (illegal[i])
      );
   end

   logic             any_illegal;
   logic [WIDTH-1:0] err_flag_q, err_flag_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   assign any_illegal = |illegal;

   // Clear first, then apply this edge's events so a coincident event survives the clear.
   always_comb begin
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      if (bus.clr_err) begin
         err_flag_d = '0;
         err_cnt_d  = '0;
      end
      if (any_illegal) begin
         err_flag_d = err_flag_d | illegal;
         if (err_cnt_d != CntMax) begin
            err_cnt_d = err_cnt_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         err_flag_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.Q        = q;
   assign bus.nQ       = nq;
   assign bus.err_flag = err_flag_q;
   assign bus.err_cnt  = err_cnt_q;

endmodule

// File: doc/sr_register_bank.md
Name: sr_register_bank

Overview:
- Parametrised successor to the single clocked SR latch: a bank of WIDTH independent, edge-triggered SR storage channels sharing one clock.
- Each channel has a selectable S=R=1 resolution mode and a global enable.
- Illegal-input detection: sticky per-channel flags plus a saturating event counter.
- Used as a control/status flag register wherever set/clear pulses from several sources land on one bit.

Parameters:
- WIDTH, 4, number of SR channels.
- MODE, 0, S=R=1 resolution: 0 reset-dominant, 1 set-dominant, 2 toggle (JK), 3 hold-and-flag.
- INIT_VAL, 0, WIDTH-bit reset value of Q.
- CNT_W, 8, width of the illegal-event counter.

Ports:
- clk  in  1  rising-edge clock.
- nRst  in  1  asynchronous active-low reset.
- en  in  1  update enable; when 0 all channels hold and no errors are recorded.
- S  in  WIDTH  per-channel set request.
- R  in  WIDTH  per-channel reset request.
- clr_err  in  1  single-cycle clear of err_flag and err_cnt.
- Q  out  WIDTH  stored state.
- nQ  out  WIDTH  complement of Q.
- err_flag  out  WIDTH  sticky per-channel illegal-input flag.
- err_cnt  out  CNT_W  saturating count of cycles with at least one illegal channel.

Behaviour:
- Reset (nRst=0, asynchronous, regardless of clk):
  - Q=INIT_VAL, nQ=~INIT_VAL.
  - err_flag=0, err_cnt=0.
  - Reset mid-operation discards all state immediately.
- Updates occur only on a rising clk edge with en=1. Q changes one edge after the inputs are sampled (latency 1).
- Per channel i, on an enabled edge:
  - S=0, R=0: hold.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: depends on MODE:
    - MODE 0: Q=0.
    - MODE 1: Q=1.
    - MODE 2: Q=~Q.
    - MODE 3: hold.
- nQ is always the exact registered complement of Q. Q[i]==nQ[i] never occurs, including during and after reset.
- Illegal event:
  - Condition: en=1 and S[i]=R[i]=1 with MODE 0, 1 or 3. In MODE 2 this input is legal and never flags.
  - Effect: err_flag[i] sets on that edge and stays set until clr_err or reset.
- err_cnt:
  - Increments by 1 per enabled edge on which any channel is illegal. Several simultaneous illegal channels still count as +1.
  - Saturates at 2^CNT_W-1 with no wrap.
- clr_err=1 on an edge clears err_flag and err_cnt. If an illegal event occurs on the same edge, the new event wins:
  - only the offending channels' flags end set;
  - err_cnt=1.
- clr_err acts even when en=0.
- en=0: Q, nQ, err_flag and err_cnt hold; S and R are ignored; only clr_err has effect.
- Unknown MODE values are a parameter error; the implementation rejects them at elaboration.

Optional Feature:
- Macro: SR_BANK_SYNC_EN.
- Defined:
  - S and R each pass through a 2-flop synchroniser. The synchroniser flops reset to 0 on nRst.
  - Input-to-Q latency becomes 3 edges.
  - en and clr_err are not synchronised.
  - Illegal detection uses the synchronised S and R values.
- Undefined: no synchroniser; latency 1 edge; S and R are sampled directly.

Decomposition:
- Shared package/include sr_bank_pkg:
  - mode constants SR_MODE_RDOM=0, SR_MODE_SDOM=1, SR_MODE_TOGGLE=2, SR_MODE_HOLD=3;
  - the default CNT_W.
- Sub-module sr_cell: one channel.
  - Inputs: clk, nRst, en, s, r, init value.
  - Outputs: q, nq, illegal pulse.
  - MODE is passed as a parameter.
- Top level instantiates WIDTH sr_cell instances via generate. It owns the err_flag register, the OR-reduction and the saturating counter.

Test Plan:
- Reset check: WIDTH=4, INIT_VAL=4'b1010, pulse nRst low between edges -> Q=1010 and nQ=0101 immediately (asynchronously), err_cnt=0.
- Basic set/reset: S=0001 then R=0001 then S=R=0 -> Q[0] goes 1, then 0, then holds 0, each change one edge after the inputs.
- Conflict per mode (S=R=0001, Q[0]=1):
  - MODE0 -> Q[0]=0, err_flag=0001, err_cnt=1;
  - MODE1 -> Q[0]=1, flag set;
  - MODE2 -> Q[0] toggles every edge, no flag;
  - MODE3 -> Q[0] holds, flag set.
- Counting and clear: MODE0, S=R=1111 for 3 edges -> err_cnt=3 (not 12). Then clr_err with S=R=0010 on the same edge -> err_flag=0010, err_cnt=1.
- Enable and saturation:
  - en=0 with S=1111 -> Q unchanged, no errors.
  - CNT_W=2, 5 illegal edges -> err_cnt saturates at 3.
- With SR_BANK_SYNC_EN: S[0] pulses 1 for one cycle -> Q[0] rises on the 3rd edge. Reset mid-pipeline -> Q returns to INIT_VAL and the pulse is lost.
